// File: rtl/ex_stage_p.sv
// ex_stage_p: registered execute stage.
// Forwarding muxes, single-cycle ALU, iterative multiplier, EX/MEM register.
module ex_stage_p #(
    parameter int XLEN       = 32,
    parameter int MUL_LAT    = 4,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_valid,
    output logic                  id_ready,
    input  logic [3:0]            alu_op,
    input  logic [6:0]            op,
    input  logic                  isForw_ON,
    input  logic [1:0]            forwA,
    input  logic [1:0]            forwB,
    input  logic [XLEN-1:0]       exmem_result,
    input  logic [XLEN-1:0]       memwb_result,
    input  logic [XLEN-1:0]       data1,
    input  logic [XLEN-1:0]       data2,
    input  logic [XLEN-1:0]       s_data,
    input  logic [REG_ADDR_W-1:0] rd_in,
    input  logic                  mem_stall,
    input  logic                  flush,
    output logic                  ex_valid,
    output logic [XLEN-1:0]       ex_result,
    output logic [XLEN-1:0]       ex_sdata,
    output logic [REG_ADDR_W-1:0] ex_rd,
    output logic [6:0]            ex_op,
    output logic                  Z,
    output logic                  N,
    output logic                  C,
    output logic                  V
);

    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam int SHW = $clog2(XLEN);
    localparam int CW  = $clog2(MUL_LAT) + 1;
    // multiplier bits retired per step; MUL_LAT-1 steps cover XLEN bits
    localparam int K   = (XLEN + MUL_LAT - 2) / (MUL_LAT - 1);
    localparam logic [XLEN-1:0] DMASK = {XLEN{1'b1}} >> (XLEN - K);
    localparam int M   = XLEN - 1;

    typedef enum logic {
        S_IDLE,
        S_MUL_BUSY
    } state_t;

    state_t          r_state, w_state_nxt;
    logic [CW-1:0]   r_cnt, w_cnt_nxt;

    logic [1:0]      w_sel_a, w_sel_b;
    logic            w_is_store, w_is_mul;
    logic [XLEN-1:0] w_fwd_b_src, w_fwd_a, w_fwd_b;
    logic [XLEN-1:0] w_op1, w_op2, w_sdata;
    logic [SHW-1:0]  w_shamt;
    logic [XLEN:0]   w_sum, w_dif;
    logic [XLEN-1:0] w_res;
    logic            w_c, w_v;

    logic            w_accept, w_accept_alu, w_accept_mul;
    logic            w_mul_step, w_mul_done;
    logic [XLEN-1:0] w_pp, w_acc_nxt;

    logic [XLEN-1:0]       r_mcand, r_mplier, r_acc, r_msdata;
    logic [REG_ADDR_W-1:0] r_mrd;
    logic [6:0]            r_mop;

    function automatic logic [XLEN-1:0] fwd_mux(
        input logic [1:0]      sel,
        input logic [XLEN-1:0] reg_v,
        input logic [XLEN-1:0] exmem_v,
        input logic [XLEN-1:0] memwb_v
    );
        case (sel)
            2'b01:   fwd_mux = exmem_v;
            2'b10:   fwd_mux = memwb_v;
            default: fwd_mux = reg_v;
        endcase
    endfunction

    assign w_sel_a     = isForw_ON ? forwA : 2'b00;
    assign w_sel_b     = isForw_ON ? forwB : 2'b00;
    assign w_is_store  = (op == OP_STORE);
    assign w_is_mul    = (alu_op == 4'd10);
    assign w_fwd_b_src = w_is_store ? s_data : data2;
    assign w_fwd_a     = fwd_mux(w_sel_a, data1, exmem_result, memwb_result);
    assign w_fwd_b     = fwd_mux(w_sel_b, w_fwd_b_src, exmem_result, memwb_result);
    assign w_op1       = w_fwd_a;
    assign w_op2       = w_is_store ? data2 : w_fwd_b;
    assign w_sdata     = w_is_store ? w_fwd_b : s_data;
    assign w_shamt     = w_op2[SHW-1:0];

    assign w_sum = {1'b0, w_op1} + {1'b0, w_op2};
    assign w_dif = {1'b0, w_op1} + {1'b0, ~w_op2} + {{XLEN{1'b0}}, 1'b1};

    // single-cycle ALU result and arithmetic flags
    always_comb begin
        w_res = '0;
        w_c   = 1'b0;
        w_v   = 1'b0;
        case (alu_op)
            4'd0: begin
                w_res = w_sum[M:0];
                w_c   = w_sum[XLEN];
                w_v   = (w_op1[M] == w_op2[M]) && (w_sum[M] != w_op1[M]);
            end
            4'd1: begin
                w_res = w_dif[M:0];
                w_c   = w_dif[XLEN];
                w_v   = (w_op1[M] != w_op2[M]) && (w_dif[M] != w_op1[M]);
            end
            4'd2: w_res = w_op1 & w_op2;
            4'd3: w_res = w_op1 | w_op2;
            4'd4: w_res = w_op1 ^ w_op2;
            4'd5: w_res = w_op1 << w_shamt;
            4'd6: w_res = w_op1 >> w_shamt;
            4'd7: w_res = $unsigned($signed(w_op1) >>> w_shamt);
            4'd8: w_res = {{(XLEN-1){1'b0}}, $signed(w_op1) < $signed(w_op2)};
            4'd9: w_res = {{(XLEN-1){1'b0}}, w_op1 < w_op2};
            default: w_res = '0;
        endcase
    end

    assign id_ready     = !mem_stall && (r_state == S_IDLE);
    assign w_accept     = id_valid && id_ready && !flush;
    assign w_accept_alu = w_accept && !w_is_mul;
    assign w_accept_mul = w_accept && w_is_mul;

    // the last step only fires when the result can be written downstream
    assign w_mul_step = (r_state == S_MUL_BUSY) && !flush &&
                        ((r_cnt > CW'(1)) || !mem_stall);
    assign w_mul_done = (r_state == S_MUL_BUSY) && !flush &&
                        (r_cnt == CW'(1)) && !mem_stall;

    assign w_pp      = r_mcand * (r_mplier & DMASK);
    assign w_acc_nxt = r_acc + w_pp;

    // FSM state and latency counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // next state: flush wins, completion holds at count 1 under stall
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        if (flush) begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept_mul) begin
                        w_state_nxt = S_MUL_BUSY;
                        w_cnt_nxt   = CW'(MUL_LAT - 1);
                    end
                end
                S_MUL_BUSY: begin
                    if (r_cnt > CW'(1)) begin
                        w_cnt_nxt = r_cnt - CW'(1);
                    end else if (!mem_stall) begin
                        w_state_nxt = S_IDLE;
                        w_cnt_nxt   = '0;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    // shift-add multiplier: K multiplier bits per busy step
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_msdata <= '0;
            r_mrd    <= '0;
            r_mop    <= '0;
        end else if (w_accept_mul) begin
            r_mcand  <= w_op1;
            r_mplier <= w_op2;
            r_acc    <= '0;
            r_msdata <= w_sdata;
            r_mrd    <= rd_in;
            r_mop    <= op;
        end else if (w_mul_step) begin
            r_acc    <= w_acc_nxt;
            r_mcand  <= r_mcand << K;
            r_mplier <= r_mplier >> K;
        end
    end

    // EX/MEM register: flush kills valid, stall holds everything
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_valid  <= 1'b0;
            ex_result <= '0;
            ex_sdata  <= '0;
            ex_rd     <= '0;
            ex_op     <= '0;
            Z         <= 1'b0;
            N         <= 1'b0;
            C         <= 1'b0;
            V         <= 1'b0;
        end else if (flush) begin
            ex_valid <= 1'b0;
        end else if (w_mul_done) begin
            ex_valid  <= 1'b1;
            ex_result <= w_acc_nxt;
            ex_sdata  <= r_msdata;
            ex_rd     <= r_mrd;
            ex_op     <= r_mop;
            Z         <= (w_acc_nxt == '0);
            N         <= w_acc_nxt[M];
            C         <= 1'b0;
            V         <= 1'b0;
        end else if (!mem_stall) begin
            ex_valid <= w_accept_alu;
            if (w_accept_alu) begin
                ex_result <= w_res;
                ex_sdata  <= w_sdata;
                ex_rd     <= rd_in;
                ex_op     <= op;
                Z         <= (w_res == '0);
                N         <= w_res[M];
                C         <= w_c;
                V         <= w_v;
            end
        end
    end

endmodule

// File: tb/tb_ex_stage_p.sv
// tb_ex_stage_p: directed checks of the registered execute stage.
// Inputs change 1ns after the rising edge; outputs are sampled there too.
module tb_ex_stage_p;

    localparam int XLEN = 32;
    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_ST = 7'b0100011;

    logic            clk = 1'b0;
    logic            rst;
    logic            id_valid;
    logic            id_ready;
    logic [3:0]      alu_op;
    logic [6:0]      op;
    logic            isForw_ON;
    logic [1:0]      forwA, forwB;
    logic [XLEN-1:0] exmem_result, memwb_result;
    logic [XLEN-1:0] data1, data2, s_data;
    logic [4:0]      rd_in;
    logic            mem_stall, flush;
    logic            ex_valid;
    logic [XLEN-1:0] ex_result, ex_sdata;
    logic [4:0]      ex_rd;
    logic [6:0]      ex_op;
    logic            Z, N, C, V;

    int errors = 0;
    int checks = 0;

    ex_stage_p #(.XLEN(32), .MUL_LAT(4), .REG_ADDR_W(5)) dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_ready(id_ready),
        .alu_op(alu_op), .op(op), .isForw_ON(isForw_ON),
        .forwA(forwA), .forwB(forwB),
        .exmem_result(exmem_result), .memwb_result(memwb_result),
        .data1(data1), .data2(data2), .s_data(s_data),
        .rd_in(rd_in), .mem_stall(mem_stall), .flush(flush),
        .ex_valid(ex_valid), .ex_result(ex_result), .ex_sdata(ex_sdata),
        .ex_rd(ex_rd), .ex_op(ex_op),
        .Z(Z), .N(N), .C(C), .V(V)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [3:0] a,
                         input logic [6:0] o, input logic [31:0] d1,
                         input logic [31:0] d2, input logic [4:0] rd);
        id_valid = v;
        alu_op   = a;
        op       = o;
        data1    = d1;
        data2    = d2;
        rd_in    = rd;
    endtask

    initial begin
        rst = 1'b1;
        id_valid = 0; alu_op = 0; op = 0; isForw_ON = 0;
        forwA = 0; forwB = 0; exmem_result = 0; memwb_result = 0;
        data1 = 0; data2 = 0; s_data = 0; rd_in = 0;
        mem_stall = 0; flush = 0;
        step();
        step();
        chk("rst_valid", ex_valid, 0);
        chk("rst_result", ex_result, 0);
        chk("rst_flags", {Z, N, C, V}, 4'b0000);
        rst = 1'b0;
        #1;
        chk("rst_ready", id_ready, 1);

        // ADD overflow, forwarding disabled even though forwA selects exmem
        forwA = 2'b01; exmem_result = 32'h1234;
        drive(1, 4'd0, OP_R, 32'h7FFF_FFFF, 32'h1, 5'd3);
        step();
        chk("add_valid", ex_valid, 1);
        chk("add_res", ex_result, 32'h8000_0000);
        chk("add_zncv", {Z, N, C, V}, 4'b0101);
        chk("add_rd", ex_rd, 5'd3);

        // SUB 5-5 with rs1 forwarded from EX/MEM
        isForw_ON = 1; forwA = 2'b01; exmem_result = 32'd5;
        drive(1, 4'd1, OP_R, 32'h99, 32'd5, 5'd4);
        step();
        chk("sub_res", ex_result, 0);
        chk("sub_zncv", {Z, N, C, V}, 4'b1010);

        // store: immediate operand, store data forwarded from MEM/WB
        forwA = 2'b00; forwB = 2'b10; memwb_result = 32'hDEAD;
        s_data = 32'h5555;
        drive(1, 4'd0, OP_ST, 32'h100, 32'd8, 5'd0);
        step();
        chk("st_res", ex_result, 32'h108);
        chk("st_sdata", ex_sdata, 32'hDEAD);
        chk("st_op", ex_op, OP_ST);

        // non-store: forwB replaces operand2, s_data passes through
        memwb_result = 32'd3;
        drive(1, 4'd0, OP_R, 32'd1, 32'h77, 5'd5);
        step();
        chk("fwdb_res", ex_result, 32'd4);
        chk("fwdb_sdata", ex_sdata, 32'h5555);

        isForw_ON = 0; forwB = 2'b00;
        drive(1, 4'd7, OP_R, 32'h8000_0000, 32'd4, 5'd6);
        step();
        chk("sra_res", ex_result, 32'hF800_0000);
        chk("sra_cv", {C, V}, 2'b00);
        drive(1, 4'd5, OP_R, 32'd1, 32'd33, 5'd6);
        step();
        chk("sll_mod", ex_result, 32'd2);
        drive(1, 4'd8, OP_R, 32'hFFFF_FFFF, 32'd1, 5'd6);
        step();
        chk("slt", ex_result, 32'd1);
        drive(1, 4'd9, OP_R, 32'hFFFF_FFFF, 32'd1, 5'd6);
        step();
        chk("sltu", ex_result, 32'd0);
        chk("sltu_z", Z, 1);
        drive(1, 4'd12, OP_R, 32'h55, 32'h66, 5'd6);
        step();
        chk("op12", ex_result, 32'd0);

        drive(0, 4'd0, OP_R, 32'd9, 32'd9, 5'd7);
        step();
        chk("bubble", ex_valid, 0);

        // MUL latency 4; a pending ADD waits until the stage is free
        drive(1, 4'd10, OP_R, 32'h0000_FFFF, 32'h0001_0001, 5'd8);
        #1;
        chk("mul_rdy0", id_ready, 1);
        step();
        drive(1, 4'd0, OP_R, 32'd10, 32'd20, 5'd9);
        for (int i = 1; i <= 3; i++) begin
            chk($sformatf("mul_busy_rdy%0d", i), id_ready, 0);
            chk($sformatf("mul_busy_val%0d", i), ex_valid, 0);
            step();
        end
        chk("mul_valid", ex_valid, 1);
        chk("mul_res", ex_result, 32'hFFFF_FFFF);
        chk("mul_rd", ex_rd, 5'd8);
        chk("mul_zncv", {Z, N, C, V}, 4'b0100);
        chk("mul_rdy_after", id_ready, 1);
        step();
        chk("post_add_res", ex_result, 32'd30);
        chk("post_add_rd", ex_rd, 5'd9);
        drive(0, 4'd0, OP_R, 0, 0, 0);
        step();

        // MUL completion stalled for 3 cycles
        drive(1, 4'd10, OP_R, 32'd3, 32'd7, 5'd10);
        step();
        drive(1, 4'd0, OP_R, 32'd5, 32'd6, 5'd11);
        step();
        step();
        mem_stall = 1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("stall_rdy%0d", i), id_ready, 0);
            step();
            chk($sformatf("stall_val%0d", i), ex_valid, 0);
        end
        mem_stall = 0;
        step();
        chk("smul_valid", ex_valid, 1);
        chk("smul_res", ex_result, 32'd21);
        chk("smul_rd", ex_rd, 5'd10);
        step();
        chk("sadd_res", ex_result, 32'd11);
        chk("sadd_rd", ex_rd, 5'd11);

        // stall holds a valid EX/MEM entry and blocks acceptance
        mem_stall = 1;
        drive(1, 4'd2, OP_R, 32'hF0, 32'h0F, 5'd12);
        step();
        chk("hold_valid", ex_valid, 1);
        chk("hold_res", ex_result, 32'd11);
        mem_stall = 0;
        step();
        chk("unhold_res", ex_result, 32'd0);
        chk("unhold_z", Z, 1);

        // flush kills an in-flight MUL
        drive(1, 4'd10, OP_R, 32'd6, 32'd7, 5'd13);
        step();
        drive(0, 4'd0, OP_R, 0, 0, 0);
        step();
        flush = 1;
        step();
        flush = 0;
        chk("flush_valid", ex_valid, 0);
        chk("flush_rdy", id_ready, 1);
        drive(1, 4'd0, OP_R, 32'd1, 32'd1, 5'd14);
        step();
        chk("fadd_valid", ex_valid, 1);
        chk("fadd_res", ex_result, 32'd2);
        drive(0, 4'd0, OP_R, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            step();
            chk($sformatf("no_mul_%0d", i), ex_valid, 0);
        end

        // asynchronous reset in the middle of a MUL
        drive(1, 4'd10, OP_R, 32'd9, 32'd9, 5'd15);
        step();
        drive(0, 4'd0, OP_R, 0, 0, 0);
        #2;
        rst = 1;
        #1;
        chk("arst_valid", ex_valid, 0);
        chk("arst_res", ex_result, 0);
        chk("arst_rd", ex_rd, 0);
        chk("arst_rdy", id_ready, 1);
        rst = 0;
        repeat (5) begin
            step();
            chk("arst_nomul", ex_valid, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
